keyboard_tone_gen: RTL and testbench
====================================

KEYBOARD_TONE_GEN -- requirements
Module: keyboard_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 1, debounce time; DEB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS.
REQ-003 SHALL have parameter NUM_KEYS, default 8, number of key inputs, range 1..16.
REQ-004 SHALL have parameter DIV_W, default 24, divider width in bits.
REQ-005 SHALL have parameter DIV_TABLE, default {23860,21302,18977,17906,15944,14204,12654,11943} packed NUM_KEYS*DIV_W bits, half-period per key; key k occupies bits [k*DIV_W +: DIV_W].
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port btn_raw, input, NUM_KEYS, asynchronous active-high key inputs.
REQ-009 SHALL have port octave, input, 2, right-shift of the selected divider (0..3).
REQ-010 SHALL have port volume, input, 4, amplitude duty (0 = mute, 15 = 15/16).
REQ-011 SHALL have port tone_out, output, 1, raw square wave.
REQ-012 SHALL have port pwm_out, output, 1, tone_out gated by volume PWM.
REQ-013 SHALL have port btn_stable, output, NUM_KEYS, debounced key state.
REQ-014 SHALL have port note_div_out, output, DIV_W, active half-period (0 when silent).
REQ-015 SHALL have port gate, output, 1, high while any debounced key is held.
REQ-016 SHALL have port note_counter, output, 32, count of note onsets.

Function
REQ-017 SHALL pass each btn_raw bit through a 2-flop synchroniser before debounce.
REQ-018 SHALL update btn_stable[k] only after the synchronised bit differs from btn_stable[k] for DEB_CYC consecutive cycles; any agreeing cycle clears that key's counter.
REQ-019 SHALL select the lowest-index set bit of btn_stable as the active key; gate = |btn_stable.
REQ-020 SHALL compute div = DIV_TABLE[active] >> octave, clamped to a minimum of 1, registered into note_div_out one cycle after btn_stable/octave change.
REQ-021 SHALL, while gate=1, toggle tone_out when the half-period counter reaches div-1 and wrap the counter to 0, giving exactly div cycles high and div cycles low.
REQ-022 SHALL, on any change of note_div_out (key change, octave change, or silence-to-key), clear the half-period counter and drive tone_out=1, so the first high phase is exactly div cycles.
REQ-023 SHALL hold tone_out=0 and the half-period counter at 0 while gate=0; note_div_out=0.
REQ-024 SHALL run a free 4-bit counter p; pwm_out = tone_out AND (p < volume); volume=0 forces pwm_out=0.
REQ-025 SHALL increment note_counter by 1 on each gate 0->1 transition only (not on key change while held), wrapping 0xFFFFFFFF->0.
REQ-026 SHALL treat simultaneous press/release of multiple keys by priority only; releasing the active key while a higher-index key is held SHALL switch to that key per REQ-022 without a note_counter increment.

Reset
REQ-027 SHALL, while rst_n=0, force tone_out=0, pwm_out=0, btn_stable=0, note_div_out=0, gate=0, note_counter=0, and clear all synchroniser, debounce, half-period and PWM counters.
REQ-028 SHALL, if reset asserts mid-note, resume from silence; a key still held after release SHALL re-debounce (DEB_CYC) and count as a new onset.

Verification
REQ-029 SHALL cover: defaults, octave=0, volume=15, press key 0 for 2 ms -> btn_stable=0x01, note_counter=1, tone_out high=23860 / low=23860 cycles.
REQ-030 SHALL cover: key 2 with octave=2 -> note_div_out=4744, tone_out high=low=4744 cycles.
REQ-031 SHALL cover: keys 1 and 3 held -> key 1 active (21302); release key 1 -> 17906 with first high phase 17906 cycles, note_counter unchanged.
REQ-032 SHALL cover: 10-cycle glitch pulses on btn_raw[0] every 100 cycles for 1 ms -> btn_stable stays 0, note_counter=0.
REQ-033 SHALL cover: volume=4 during a high phase -> pwm_out high 4 of every 16 cycles; volume=0 -> pwm_out constant 0.
REQ-034 SHALL cover: rst_n low for 5 cycles mid-note with key held -> all outputs 0 immediately; tone resumes DEB_CYC+ cycles after release, note_counter=1.

Source files
------------

// File: rtl/keyboard_tone_gen.sv
// Debounced multi-key square-wave tone generator.
// Lowest-index key wins; octave shifts the divider; volume sets the PWM duty.
module keyboard_tone_gen #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int DEBOUNCE_MS = 1,
    parameter int NUM_KEYS    = 8,
    parameter int DIV_W       = 24,
    parameter logic [NUM_KEYS*DIV_W-1:0] DIV_TABLE = {
        24'd11943, 24'd12654, 24'd14204, 24'd15944,
        24'd17906, 24'd18977, 24'd21302, 24'd23860}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] btn_raw,
    input  logic [1:0]          octave,
    input  logic [3:0]          volume,
    output logic                tone_out,
    output logic                pwm_out,
    output logic [NUM_KEYS-1:0] btn_stable,
    output logic [DIV_W-1:0]    note_div_out,
    output logic                gate,
    output logic [31:0]         note_counter
);

    localparam int DEB_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEB_EFF = (DEB_CYC < 1) ? 1 : DEB_CYC;
    localparam int CNT_W   = $clog2(DEB_EFF + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_EFF - 1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [CNT_W-1:0]    r_deb_cnt [NUM_KEYS];
    logic [DIV_W-1:0]    r_note_div;
    logic [DIV_W-1:0]    r_hp_cnt;
    logic                r_tone;
    logic [3:0]          r_p;
    logic [31:0]         r_note_cnt;

    logic [NUM_KEYS-1:0] w_stab_nxt;
    logic [4:0]          w_active;
    logic                w_found;
    logic                w_gate;
    logic [DIV_W-1:0]    w_base;
    logic [DIV_W-1:0]    w_shift;
    logic [DIV_W-1:0]    w_div;

    // A key flips only on its DEB_EFF-th consecutive disagreeing cycle
    always_comb begin
        w_stab_nxt = r_stable;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_sync2[k] != r_stable[k] && r_deb_cnt[k] == DEB_LAST)
                w_stab_nxt[k] = ~r_stable[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_deb_cnt[k] <= '0;
        end else begin
            r_sync1  <= btn_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stab_nxt;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (r_sync2[k] == r_stable[k] || r_deb_cnt[k] == DEB_LAST)
                    r_deb_cnt[k] <= '0;
                else
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        w_active = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_stable[k] && !w_found) begin
                w_active = 5'(k);
                w_found  = 1'b1;
            end
        end
    end

    assign w_gate  = |r_stable;
    assign w_base  = DIV_TABLE[32'(w_active)*DIV_W +: DIV_W];
    assign w_shift = w_base >> octave;

    always_comb begin
        w_div = '0;
        if (w_gate)
            w_div = (w_shift == '0) ? DIV_W'(1) : w_shift;
    end

    // Any new divider restarts the tone on a fresh, full high phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note_div <= '0;
            r_hp_cnt   <= '0;
            r_tone     <= 1'b0;
        end else begin
            r_note_div <= w_div;
            if (w_div == '0) begin
                r_tone   <= 1'b0;
                r_hp_cnt <= '0;
            end else if (w_div != r_note_div) begin
                r_tone   <= 1'b1;
                r_hp_cnt <= '0;
            end else if (r_hp_cnt == r_note_div - 1'b1) begin
                r_tone   <= ~r_tone;
                r_hp_cnt <= '0;
            end else begin
                r_hp_cnt <= r_hp_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= '0;
            r_note_cnt <= '0;
        end else begin
            r_p <= r_p + 1'b1;
            if (r_stable == '0 && w_stab_nxt != '0)
                r_note_cnt <= r_note_cnt + 1'b1;
        end
    end

    assign tone_out     = r_tone & w_gate;
    assign pwm_out      = tone_out & (r_p < volume);
    assign btn_stable   = r_stable;
    assign note_div_out = r_note_div;
    assign gate         = w_gate;
    assign note_counter = r_note_cnt;

endmodule

// File: tb/tb_keyboard_tone_gen.sv
// Bench for keyboard_tone_gen: per-cycle model comparison plus directed checks.
module tb_keyboard_tone_gen;

    localparam int NK     = 8;
    localparam int DW     = 24;
    localparam int CLK_HZ = 20_000;
    localparam int DEB    = 20;
    localparam logic [NK*DW-1:0] TBL = {
        24'd29, 24'd31, 24'd35, 24'd40,
        24'd44, 24'd47, 24'd53, 24'd60};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] btn_raw = '0;
    logic [1:0]    octave = '0;
    logic [3:0]    volume = 4'd15;
    logic          tone_out, pwm_out, gate;
    logic [NK-1:0] btn_stable;
    logic [DW-1:0] note_div_out;
    logic [31:0]   note_counter;

    int checks = 0;
    int failures = 0;

    keyboard_tone_gen #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(1), .NUM_KEYS(NK),
        .DIV_W(DW), .DIV_TABLE(TBL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .octave(octave), .volume(volume),
        .tone_out(tone_out), .pwm_out(pwm_out),
        .btn_stable(btn_stable), .note_div_out(note_div_out),
        .gate(gate), .note_counter(note_counter)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endfunction

    // Active divider: table entry of lowest held key, shifted, at least 1
    function automatic int mdiv(logic [NK-1:0] st, logic [1:0] oc);
        int d;
        for (int k = 0; k < NK; k++) begin
            if (st[k]) begin
                d = int'(TBL[k*DW +: DW]) >> oc;
                return (d == 0) ? 1 : d;
            end
        end
        return 0;
    endfunction

    logic [NK-1:0] m_s1, m_s2, m_stab, m_old;
    int m_run [NK];
    int m_div, m_nd, m_cyc, m_onset, m_nc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
            m_div = 0; m_cyc = 0; m_onset = 0; m_nc = 0;
        end else begin
            m_old = m_stab;
            m_nd = mdiv(m_stab, octave);
            for (int k = 0; k < NK; k++) begin
                if (m_s2[k] != m_stab[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_stab[k] = ~m_stab[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_cyc++;
            if (m_old == '0 && m_stab != '0) m_nc++;
            if (m_nd != m_div) m_onset = m_cyc;
            m_div = m_nd;
        end
    end

    logic e_tone, e_pwm;
    always @(posedge clk) begin
        #1;
        e_tone = 1'b0;
        if (m_div != 0 && m_stab != '0)
            e_tone = (((m_cyc - m_onset) / m_div) % 2) == 0;
        e_pwm = e_tone && ((m_cyc % 16) < int'(volume));
        chk("cyc_tone_out", tone_out, e_tone);
        chk("cyc_pwm_out", pwm_out, e_pwm);
        chk("cyc_btn_stable", btn_stable, m_stab);
        chk("cyc_note_div_out", note_div_out, m_div);
        chk("cyc_gate", gate, m_stab != '0);
        chk("cyc_note_counter", note_counter, m_nc);
    end

    task automatic smp;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input int exp, input string nm);
        int h, l, n;
        smp;
        n = 0;
        while (tone_out !== 1'b0 && n < 500) begin smp; n++; end
        n = 0;
        while (tone_out !== 1'b1 && n < 500) begin smp; n++; end
        h = 0;
        while (tone_out === 1'b1 && h < 500) begin smp; h++; end
        l = 0;
        while (tone_out === 1'b0 && l < 500) begin smp; l++; end
        chk({nm, "_high"}, h, exp);
        chk({nm, "_low"}, l, exp);
    endtask

    initial begin
        int n, h, cnt;
        cyc(3);
        chk("rst_tone", tone_out, 0);
        chk("rst_stable", btn_stable, 0);
        chk("rst_div", note_div_out, 0);
        chk("rst_count", note_counter, 0);
        rst_n = 1'b1;

        // short glitches never pass debounce
        for (int g = 0; g < 5; g++) begin
            btn_raw[0] = 1'b1; cyc(10);
            btn_raw[0] = 1'b0; cyc(90);
        end
        chk("glitch_stable", btn_stable, 0);
        chk("glitch_count", note_counter, 0);

        btn_raw = 8'h01;
        cyc(DEB + 5);
        chk("k0_stable", btn_stable, 8'h01);
        chk("k0_count", note_counter, 1);
        chk("k0_div", note_div_out, 60);
        measure(60, "k0");

        @(negedge clk);
        btn_raw = 8'h04; octave = 2'd2;
        cyc(DEB + 5);
        chk("k2_div", note_div_out, 11);
        chk("k2_count", note_counter, 1);
        measure(11, "k2");

        @(negedge clk);
        btn_raw = 8'h0A; octave = 2'd0;
        cyc(DEB + 5);
        chk("k13_div", note_div_out, 53);
        btn_raw = 8'h08;
        n = 0;
        smp;
        while (note_div_out != 44 && n < 100) begin smp; n++; end
        h = 0;
        while (tone_out === 1'b1 && h < 500) begin smp; h++; end
        chk("k3_first_high", h, 44);
        chk("k3_count", note_counter, 1);

        @(negedge clk);
        btn_raw = '0;
        cyc(DEB + 5);
        chk("off_gate", gate, 0);
        chk("off_div", note_div_out, 0);

        btn_raw = 8'h01;
        n = 0;
        smp;
        while (tone_out !== 1'b1 && n < 100) begin smp; n++; end
        @(negedge clk);
        volume = 4'd4;
        cnt = 0;
        repeat (16) begin smp; cnt += int'(pwm_out); end
        chk("vol4_pwm_high", cnt, 4);
        @(negedge clk);
        volume = 4'd0;
        cnt = 0;
        repeat (40) begin smp; cnt += int'(pwm_out); end
        chk("vol0_pwm_high", cnt, 0);
        chk("vol_count", note_counter, 2);
        @(negedge clk);
        volume = 4'd15;
        cyc(30);

        rst_n = 1'b0;
        #1;
        chk("mid_rst_tone", tone_out, 0);
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_stable", btn_stable, 0);
        chk("mid_rst_gate", gate, 0);
        chk("mid_rst_div", note_div_out, 0);
        chk("mid_rst_count", note_counter, 0);
        cyc(5);
        rst_n = 1'b1;
        cnt = 0;
        repeat (DEB) begin smp; cnt += int'(tone_out); end
        chk("post_rst_quiet", cnt, 0);
        n = 0;
        while (tone_out !== 1'b1 && n < 50) begin smp; n++; end
        chk("post_rst_tone", tone_out, 1);
        chk("post_rst_count", note_counter, 1);
        chk("post_rst_div", note_div_out, 60);
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
